// File: rtl/div_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// div_unit
//   Iterative radix-2 restoring divider for DIV/DIVU in the execute stage.
//   Produces the quotient (LO) and remainder (HI) for the HI/LO register write,
//   holding the pipeline through stall_o while a division is in flight.
//   One quotient bit is produced per BUSY cycle; results are sign-fixed and
//   registered on the edge that enters DONE.
//
// Parameters
//   WIDTH      operand width; quotient and remainder are each WIDTH bits
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   start_i    DIV/DIVU in execute; held high while the instruction sits in E
//   signed_i   1 = DIV (two's complement), 0 = DIVU; sampled with start_i
//   annul_i    execute-stage flush; aborts the operation
//   a_i        dividend (rs)
//   b_i        divisor (rt)
//   lo_o       quotient
//   hi_o       remainder
//   ready_o    one-cycle pulse; hi_o/lo_o valid, HI/LO write must occur
//   busy_o     a division step is in progress
//   stall_o    combinational pipeline hold
//
// Configuration macro
//   DIV_ZERO_FAST_EN  when defined, a zero divisor seen at start skips the
//                     BUSY phase and goes straight to DONE.
// -----------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic             annul_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o,
    output logic             ready_o,
    output logic             busy_o,
    output logic             stall_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    count;

    // Working registers of the iteration.
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] dividend_raw;
    logic             sign_q;
    logic             sign_r;

    logic             accept;
    logic             zero_fast;
    logic             last_step;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    // Restoring step datapath.
    logic [WIDTH:0]   shifted;
    logic             borrow;
    logic [WIDTH-1:0] diff;
    logic             nonneg;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

    assign accept    = start_i & ~annul_i;
    assign last_step = (count == CW'(WIDTH - 1));

    assign a_abs = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    assign b_abs = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

`ifdef DIV_ZERO_FAST_EN
    assign zero_fast = (b_i == '0);
`else
    assign zero_fast = 1'b0;
`endif

    // The shifted partial remainder is WIDTH+1 bits wide. If its top bit is
    // set it certainly exceeds the divisor, so the subtraction is kept even
    // though the WIDTH-bit trial reports a borrow; the WIDTH-bit difference
    // is still exact because the true result is below the divisor.
    assign shifted          = {rem, quo[WIDTH-1]};
    assign {borrow, diff}   = {1'b0, shifted[WIDTH-1:0]} - {1'b0, divisor};
    assign nonneg           = shifted[WIDTH] | ~borrow;
    assign step_rem         = nonneg ? diff : shifted[WIDTH-1:0];
    assign step_quo         = {quo[WIDTH-2:0], nonneg};

    // NOTE: clocked processes use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        ready_o    = 1'b0;
        busy_o     = 1'b0;
        stall_o    = 1'b0;
        unique case (state)
            IDLE: begin
                stall_o = accept;
                if (accept) begin
                    state_next = zero_fast ? DONE : BUSY;
                end
            end
            BUSY: begin
                busy_o  = 1'b1;
                stall_o = 1'b1;
                if (annul_i) begin
                    state_next = IDLE;
                end else if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // start_i here is the same instruction still in E: ignored.
                ready_o    = ~annul_i;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the iteration registers carry no reset; they are always loaded in
    // IDLE before BUSY reads them, so resetting them would only add logic.
    always_ff @(posedge clk) begin
        if (state == IDLE && accept) begin
            divisor      <= b_abs;
            quo          <= a_abs;
            rem          <= '0;
            dividend_raw <= a_i;
            sign_q       <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            sign_r       <= signed_i & a_i[WIDTH-1];
        end else if (state == BUSY && !annul_i) begin
            rem <= step_rem;
            quo <= step_quo;
        end
    end

    // Step counter and architectural results. An annulled division never
    // reaches the result update, so hi_o/lo_o keep the previous values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            hi_o  <= '0;
            lo_o  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        count <= '0;
                        if (zero_fast) begin
                            lo_o <= '1;
                            hi_o <= a_i;
                        end
                    end
                end
                BUSY: begin
                    if (!annul_i) begin
                        count <= count + 1'b1;
                        if (last_step) begin
                            // Zero divisor overrides the sign fix for both
                            // DIV and DIVU.
                            if (divisor == '0) begin
                                lo_o <= '1;
                                hi_o <= dividend_raw;
                            end else begin
                                lo_o <= sign_q ? -step_quo : step_quo;
                                hi_o <= sign_r ? -step_rem : step_rem;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_div_unit
//   Self-checking bench for div_unit: a table of directed vectors, hand-built
//   sequences for back-to-back issue, annul and reset, and randomized operands
//   checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_div_unit;

    localparam int W = 32;
`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST_ZERO = 1'b1;
`else
    localparam bit FAST_ZERO = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic         signed_i;
    logic         annul_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic [W-1:0] lo_o;
    logic [W-1:0] hi_o;
    logic         ready_o;
    logic         busy_o;
    logic         stall_o;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sgn;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
    } vec_t;

    vec_t vecs[12];

    div_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .signed_i (signed_i),
        .annul_i  (annul_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .lo_o     (lo_o),
        .hi_o     (hi_o),
        .ready_o  (ready_o),
        .busy_o   (busy_o),
        .stall_o  (stall_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero, remainder
    // taking the dividend's sign; zero divisor yields all ones / dividend.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic sgn,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa;
        longint sb;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (sgn) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Issue one divide starting at the current drive point (just after a
    // rising edge, DUT idle). Checks ready timing, stall span and results.
    // With b2b set, start_i stays high through DONE and the task returns at
    // the drive point of the following cycle.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sgn, input logic [W-1:0] exp_lo,
                         input logic [W-1:0] exp_hi, input bit b2b);
        int           lat;
        int           last;
        int           first_rdy;
        int           n_rdy;
        int           n_stall;
        logic [W-1:0] got_lo;
        logic [W-1:0] got_hi;
        lat       = (b == '0 && FAST_ZERO) ? 1 : W + 1;
        last      = b2b ? lat : lat + 2;
        first_rdy = -1;
        n_rdy     = 0;
        n_stall   = 0;
        got_lo    = lo_o;
        got_hi    = hi_o;
        a_i       = a;
        b_i       = b;
        signed_i  = sgn;
        start_i   = 1'b1;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            if (stall_o) n_stall++;
            if (ready_o) begin
                n_rdy++;
                if (first_rdy < 0) begin
                    first_rdy = c;
                    got_lo    = lo_o;
                    got_hi    = hi_o;
                end
            end
            @(posedge clk);
            #1;
            if (c == lat && !b2b) start_i = 1'b0;
        end
        check($sformatf("%s_ready_cycle", tag), first_rdy, lat);
        check($sformatf("%s_ready_count", tag), n_rdy, 1);
        check($sformatf("%s_stall_cycles", tag), n_stall, lat);
        check($sformatf("%s_lo", tag), got_lo, exp_lo);
        check($sformatf("%s_hi", tag), got_hi, exp_hi);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        logic [W-1:0] prev_lo;
        logic [W-1:0] prev_hi;
        int           n_rdy;
        int           sel;

        vecs[0]  = '{"divu_100_7",     32'd100,        32'd7,          1'b0, 32'd14,         32'd2};
        vecs[1]  = '{"div_m7_2",       32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vecs[2]  = '{"div_ovf",        32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'h0};
        vecs[3]  = '{"divu_5_0",       32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5};
        vecs[4]  = '{"div_m5_0",       32'hFFFF_FFFB,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFB};
        vecs[5]  = '{"div_7_m2",       32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1};
        vecs[6]  = '{"div_m8_m3",      32'hFFFF_FFF8,  32'hFFFF_FFFD,  1'b1, 32'd2,          32'hFFFF_FFFE};
        vecs[7]  = '{"divu_max_1",     32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0};
        vecs[8]  = '{"divu_0_5",       32'd0,          32'd5,          1'b0, 32'd0,          32'd0};
        vecs[9]  = '{"divu_big_2",     32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1};
        vecs[10] = '{"div_min_1",      32'h8000_0000,  32'd1,          1'b1, 32'h8000_0000,  32'd0};
        vecs[11] = '{"divu_3_max",     32'd3,          32'hFFFF_FFFF,  1'b0, 32'd0,          32'd3};

        rst      = 1'b1;
        start_i  = 1'b0;
        signed_i = 1'b0;
        annul_i  = 1'b0;
        a_i      = '0;
        b_i      = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_lo", lo_o, 0);
        check("reset_hi", hi_o, 0);
        check("reset_ready", ready_o, 0);
        check("reset_busy", busy_o, 0);
        check("reset_stall", stall_o, 0);
        @(posedge clk);
        #1;

        // Directed vectors.
        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].sgn,
                  vecs[i].lo, vecs[i].hi, 1'b0);
        end

        // start_i held through DONE, then a new DIVU 9/3 the next cycle.
        do_op("b2b_first", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b1);
        do_op("b2b_second", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0);
        prev_lo = 32'd3;
        prev_hi = 32'd0;

        // Annul while BUSY in cycle 10.
        a_i      = 32'd100;
        b_i      = 32'd7;
        signed_i = 1'b0;
        start_i  = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        annul_i = 1'b1;
        @(negedge clk);
        check("annul_busy_before", busy_o, 1);
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        check("annul_busy_after", busy_o, 0);
        check("annul_stall_after", stall_o, 0);
        n_rdy = 0;
        repeat (30) begin
            @(negedge clk);
            if (ready_o) n_rdy++;
        end
        check("annul_no_ready", n_rdy, 0);
        check("annul_keep_lo", lo_o, prev_lo);
        check("annul_keep_hi", hi_o, prev_hi);
        @(posedge clk);
        #1;

        // Annul arriving in the DONE cycle suppresses the ready pulse.
        a_i     = 32'd100;
        b_i     = 32'd7;
        start_i = 1'b1;
        n_rdy   = 0;
        for (int c = 0; c < W + 1; c++) begin
            @(negedge clk);
            if (ready_o) n_rdy++;
            @(posedge clk);
            #1;
        end
        annul_i = 1'b1;
        @(negedge clk);
        if (ready_o) n_rdy++;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        start_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ready_o) n_rdy++;
        end
        check("annul_done_no_ready", n_rdy, 0);
        @(posedge clk);
        #1;

        // Randomized operands against the reference model.
        for (int i = 0; i < 40; i++) begin
            ra  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0)      rb = '0;
            else if (sel < 4)  rb = $urandom_range(1, 300);
            else if (sel == 4) rb = -($urandom_range(1, 300));
            else               rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            ref_div(ra, rb, rs, eq, er);
            do_op($sformatf("rnd%0d", i), ra, rb, rs, eq, er, 1'b0);
        end

        // Reset during a division (cycle 20) clears every output.
        a_i      = 32'd100;
        b_i      = 32'd7;
        signed_i = 1'b0;
        start_i  = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        rst     = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_lo", lo_o, 0);
        check("rst_mid_hi", hi_o, 0);
        check("rst_mid_ready", ready_o, 0);
        check("rst_mid_busy", busy_o, 0);
        check("rst_mid_stall", stall_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
